// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array feed controller.
package sa_pkg;

  localparam int SIZE_DEF       = 4;
  localparam int DATA_WIDTH_DEF = 10;
  localparam int DRAIN_CYCLES   = 2;

  function automatic int latency(input int size);
    return 3 * size + 3;
  endfunction

  localparam int LATENCY_DEF = latency(SIZE_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_CAPTURE
  } state_e;

endpackage

// File: rtl/sa_feed_controller_if.sv
// Host-side operands/results and array-side feed/return signals of the feed controller.
import sa_pkg::*;

interface sa_feed_controller_if #(
  parameter int SIZE       = SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                            start;
  logic signed [DATA_WIDTH-1:0]    a_mat [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0]    b_mat [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0]    sa_a  [SIZE];
  logic signed [DATA_WIDTH-1:0]    sa_b  [SIZE];
  logic                            sa_rst_n;
  logic signed [2*DATA_WIDTH-1:0]  sa_c  [SIZE][SIZE];
  logic signed [2*DATA_WIDTH-1:0]  c_mat [SIZE][SIZE];
  logic                            busy;
  logic                            done;

  modport master (
    output start, a_mat, b_mat, sa_c,
    input  sa_a, sa_b, sa_rst_n, c_mat, busy, done
  );

  modport slave (
    input  start, a_mat, b_mat, sa_c,
    output sa_a, sa_b, sa_rst_n, c_mat, busy, done
  );
endinterface

// File: rtl/sa_skew_row.sv
// One skewed feed lane: emits vec[t-LANE] while enabled and in window, otherwise 0.
import sa_pkg::*;

module sa_skew_row #(
  parameter int SIZE       = SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANE       = 0,
  parameter int TW         = 4
) (
  input  logic                          en,
  input  logic [TW-1:0]                 t,
  input  logic signed [DATA_WIDTH-1:0]  vec [SIZE],
  output logic signed [DATA_WIDTH-1:0]  lane
);

  // Signed index compare: indices below LANE or beyond SIZE-1 select nothing.
  always_comb begin
    lane = '0;
    for (int m = 0; m < SIZE; m++) begin
      if (en && ((int'(t) - LANE) == m)) lane = vec[m];
    end
  end

endmodule

// File: rtl/sa_feed_controller.sv
// Sequences clear, skewed feed, drain and capture for an external SIZE x SIZE systolic array.
import sa_pkg::*;

module sa_feed_controller #(
  parameter int SIZE       = SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  sa_feed_controller_if.slave   bus
);

  localparam int CW = $clog2(3 * SIZE);
  localparam logic [CW-1:0] FEED_LAST  = CW'(3 * SIZE - 3);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] t_q, t_d;
  logic          sa_rst_n_q, sa_rst_n_d;
  logic          done_q, done_d;
  logic signed [DATA_WIDTH-1:0]   a_q [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0]   a_d [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0]   b_q [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0]   b_d [SIZE][SIZE];
  logic signed [2*DATA_WIDTH-1:0] c_q [SIZE][SIZE];
  logic signed [2*DATA_WIDTH-1:0] c_d [SIZE][SIZE];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    done_d  = 1'b0;
    case (state_q)
      // The done cycle is spent in IDLE without sampling start, so a held start
      // re-launches one cycle later and results never overlap the done pulse.
      S_IDLE: begin
        if (bus.start && !done_q) begin
          state_d = S_CLEAR;
          a_d     = bus.a_mat;
          b_d     = bus.b_mat;
        end
      end
      S_CLEAR: state_d = S_FEED;
      S_FEED: begin
        if (t_q == FEED_LAST) state_d = S_DRAIN;
        else                  t_d = t_q + CW'(1);
      end
      S_DRAIN: begin
        if (t_q == DRAIN_LAST) state_d = S_CAPTURE;
        else                   t_d = t_q + CW'(1);
      end
      S_CAPTURE: begin
        c_d     = bus.sa_c;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) t_d = '0;
    sa_rst_n_d = (state_d != S_CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      sa_rst_n_q <= 1'b0;
      done_q     <= 1'b0;
      a_q        <= '{default: '0};
      b_q        <= '{default: '0};
      c_q        <= '{default: '0};
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      sa_rst_n_q <= sa_rst_n_d;
      done_q     <= done_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
    end
  end

  logic feed_en;
  assign feed_en = (state_q == S_FEED);

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] row_a [SIZE];
    logic signed [DATA_WIDTH-1:0] col_b [SIZE];
    logic signed [DATA_WIDTH-1:0] lane_a, lane_b;

    for (genvar k = 0; k < SIZE; k++) begin : g_sel
      assign row_a[k] = a_q[i][k];
      assign col_b[k] = b_q[k][i];
    end

    sa_skew_row #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .LANE(i), .TW(CW)) u_row_a (
      .en(feed_en), .t(t_q), .vec(row_a), .lane(lane_a)
    );
    sa_skew_row #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .LANE(i), .TW(CW)) u_col_b (
      .en(feed_en), .t(t_q), .vec(col_b), .lane(lane_b)
    );

    assign bus.sa_a[i] = lane_a;
    assign bus.sa_b[i] = lane_b;
  end

  assign bus.c_mat    = c_q;
  assign bus.sa_rst_n = sa_rst_n_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;

endmodule
